imem_loader: RTL

- Serial program loader: the writer side of the instruction memory that the CPU fetch path only reads.
- Receives a program over an 8N1 UART line, packs bytes into 32-bit words, and writes them sequentially into instruction memory port A starting at address 0.
- Holds the CPU in reset until the load completes.
- Sits beside the CPU at top level and shares the board clock.

---
 rtl/imem_loader.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Serial program loader: UART 8N1 receiver feeding a word packer
// that writes instruction memory and holds the CPU in reset until done.
module imem_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              frame_err
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int CW   = ADDR_W + 1;

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    L_LEN, L_WORD, L_WRITE, L_DONE
  } ld_state_t;

  rx_state_t   rstate;
  ld_state_t   lstate;
  logic        rx_m;
  logic        rx_s;
  logic [TW-1:0] timer;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        byte_valid;
  logic [7:0]  rx_byte;
  logic [1:0]  byte_idx;
  logic [31:0] asm_word;
  logic [CW-1:0] remaining;

  // Two-flop synchronizer; idle line level is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // UART receiver: mid-bit sampling, one-cycle byte_valid on good stop bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate     <= R_IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      unique case (rstate)
        R_IDLE: begin
          if (!rx_s) begin
            timer  <= '0;
            rstate <= R_START;
          end
        end
        R_START: begin
          if (timer == TW'(HALF - 1)) begin
            timer   <= '0;
            bit_idx <= '0;
            rstate  <= rx_s ? R_IDLE : R_DATA;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        R_DATA: begin
          if (timer == TW'(CLKS_PER_BIT - 1)) begin
            timer <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bit_idx == 3'd7) rstate <= R_STOP;
            bit_idx <= bit_idx + 3'd1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        R_STOP: begin
          if (timer == TW'(CLKS_PER_BIT - 1)) begin
            timer  <= '0;
            rstate <= R_IDLE;
            if (rx_s) begin
              byte_valid <= 1'b1;
              rx_byte    <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // Loader: length byte, then big-endian words written sequentially.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lstate    <= L_LEN;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      cpu_hold  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      byte_idx  <= '0;
      asm_word  <= '0;
      remaining <= '0;
    end else begin
      mem_we <= 1'b0;
      if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);
      unique case (lstate)
        L_LEN: begin
          if (byte_valid) begin
            if (rx_byte == 8'd0) remaining <= CW'(1) << ADDR_W;
            else                 remaining <= CW'(rx_byte);
            busy     <= 1'b1;
            byte_idx <= '0;
            lstate   <= L_WORD;
          end
        end
        L_WORD: begin
          if (byte_valid) begin
            asm_word <= {asm_word[23:0], rx_byte};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) lstate <= L_WRITE;
          end
        end
        L_WRITE: begin
          mem_we    <= 1'b1;
          mem_din   <= asm_word;
          remaining <= remaining - CW'(1);
          if (remaining == CW'(1)) begin
            lstate   <= L_DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
          end else begin
            lstate <= L_WORD;
          end
        end
        L_DONE: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
        end
        default: lstate <= L_LEN;
      endcase
    end
  end

endmodule
